// File: rtl/nn_ops_pkg.sv
// Shared types and helpers for the non-linear-ops datapath.
// Holds the add/sub opcode, buffer states, overflow detect and saturation values.
package nn_ops_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } addsub_e;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    // Widest datapath the saturation helpers can describe.
    localparam int MAX_W = 128;

    // Signed overflow from the sign bits of a, b and the wrapped result r.
    function automatic logic ovf_addsub(
        input logic    a,
        input logic    b,
        input logic    r,
        input addsub_e op
    );
        if (op == ADD) begin
            return (a == b) && (r != a);
        end
        return (a != b) && (r != a);
    endfunction

    // Signed maximum of a w-bit value, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] sat_max(input int w);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Signed minimum of a w-bit value, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] sat_min(input int w);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == w - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/add.sv
// Shared two's-complement add/subtract unit.
// Produces the wrapped result and a signed-overflow flag.
module add
    import nn_ops_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  addsub_e          i_op,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf
);

    // Wrapped add or subtract, then flag overflow from the sign bits.
    always_comb begin
        o_sum = (i_op == SUB) ? (i_a - i_b) : (i_a + i_b);
        o_ovf = ovf_addsub(i_a[WIDTH-1], i_b[WIDTH-1], o_sum[WIDTH-1], i_op);
    end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one add unit between N_REQ requesters.
// Optional macro ADD_ARB_SAT_EN clamps overflowed results to signed max/min.
module add_arbiter
    import nn_ops_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0]            req_op,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_a,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [WIDTH-1:0]            rsp_data,
    output logic                        rsp_ovf,
    output logic [31:0]                 op_count
);

    buf_state_e       r_state;
    buf_state_e       w_state_nxt;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [N_REQ-1:0] w_grant_oh;
    logic [ID_W-1:0]  w_win;
    logic             w_any;
    logic             w_slot_free;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    addsub_e          w_op;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_result;

    assign rsp_valid   = (r_state == BUF_FULL);
    assign w_slot_free = !rsp_valid || rsp_ready;
    assign req_ready   = w_grant_oh & {N_REQ{w_slot_free}};
    assign w_accept    = w_any && w_slot_free;

    // Pick the first valid requester at or after the priority pointer.
    always_comb begin : rr_pick
        int              j;
        logic [ID_W-1:0] idx;
        w_grant_oh = '0;
        w_win      = '0;
        w_any      = 1'b0;
        j          = 0;
        idx        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            idx = ID_W'(j);
            if (!w_any && req_valid[idx]) begin
                w_any           = 1'b1;
                w_win           = idx;
                w_grant_oh[idx] = 1'b1;
            end
        end
    end

    // One-hot mux of the winner's operands into the shared adder.
    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_op = ADD;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_a  = w_a | req_a[i];
                w_b  = w_b | req_b[i];
                w_op = addsub_e'(req_op[i]);
            end
        end
    end

    add #(
        .WIDTH (WIDTH)
    ) u_add (
        .i_a   (w_a),
        .i_b   (w_b),
        .i_op  (w_op),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

`ifdef ADD_ARB_SAT_EN
    localparam logic [MAX_W-1:0] L_MAX_FULL = sat_max(WIDTH);
    localparam logic [MAX_W-1:0] L_MIN_FULL = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] L_SAT_MAX  = L_MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] L_SAT_MIN  = L_MIN_FULL[WIDTH-1:0];

    // Clamp on overflow; a wrapped negative sign means the true result was positive.
    always_comb begin
        w_result = w_sum;
        if (w_ovf) begin
            w_result = w_sum[WIDTH-1] ? L_SAT_MAX : L_SAT_MIN;
        end
    end
`else
    // Pass the wrapped two's-complement result straight through.
    always_comb begin
        w_result = w_sum;
    end
`endif

    // Output buffer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffer fills on accept and empties on a drain without a new accept.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            BUF_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (w_accept) begin
                    w_state_nxt = BUF_FULL;
                end else if (rsp_ready) begin
                    w_state_nxt = BUF_EMPTY;
                end
            end
            default: w_state_nxt = BUF_EMPTY;
        endcase
    end

    // Capture the result, advance the pointer and count on every accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_id   <= '0;
            rsp_ovf  <= 1'b0;
            r_rr_ptr <= '0;
            op_count <= '0;
        end else if (w_accept) begin
            rsp_data <= w_result;
            rsp_id   <= w_win;
            rsp_ovf  <= w_ovf;
            r_rr_ptr <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
            op_count <= op_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Directed self-checking bench for add_arbiter (WIDTH=64, N_REQ=4).
// Build with ADD_ARB_SAT_EN to check the saturating variant.
module tb_add_arbiter;

    localparam int W = 64;
    localparam int N = 4;

    logic                clk;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        req_op;
    logic [N-1:0][W-1:0] req_a;
    logic [N-1:0][W-1:0] req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_id;
    logic [W-1:0]        rsp_data;
    logic                rsp_ovf;
    logic [31:0]         op_count;

    int n_chk;
    int n_err;

    localparam logic [W-1:0] SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] SMIN = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

`ifdef ADD_ARB_SAT_EN
    localparam logic [W-1:0] EXP_SUB_OVF = SMAX;
    localparam logic [W-1:0] EXP_ADD_OVF = SMIN;
`else
    localparam logic [W-1:0] EXP_SUB_OVF = SMIN;
    localparam logic [W-1:0] EXP_ADD_OVF = SMAX;
`endif

    add_arbiter #(
        .WIDTH (W),
        .N_REQ (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_rr_operands();
        for (int i = 0; i < N; i++) begin
            req_a[i] = W'(i * 10 + 1);
            req_b[i] = W'(i);
        end
        req_op = '0;
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        #1;
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_data", rsp_data, 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        chk("rst_ovf", 64'(rsp_ovf), 64'd0);
        chk("rst_cnt", 64'(op_count), 64'd0);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Round-robin: all valid from reset, expect ids 0,1,2,3,0.
        set_rr_operands();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        chk("rr_first_grant", 64'(req_ready), 64'b0001);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("rr_valid", 64'(rsp_valid), 64'd1);
            chk("rr_id", 64'(rsp_id), 64'(c % 4));
            chk("rr_data", rsp_data, 64'(11 * (c % 4) + 1));
        end
        chk("rr_cnt", 64'(op_count), 64'd5);

        // Single add from requester 2 (pointer now at 1).
        @(negedge clk);
        req_valid = 4'b0100;
        req_a[2]  = 64'd5;
        req_b[2]  = 64'd7;
        #1;
        chk("add_ready", 64'(req_ready), 64'b0100);
        @(posedge clk);
        #1;
        chk("add_valid", 64'(rsp_valid), 64'd1);
        chk("add_data", rsp_data, 64'd12);
        chk("add_id", 64'(rsp_id), 64'd2);
        chk("add_ovf", 64'(rsp_ovf), 64'd0);
        chk("add_cnt", 64'(op_count), 64'd6);

        // Backpressure: buffer FULL, downstream stalled for 3 cycles.
        @(negedge clk);
        set_rr_operands();
        req_valid = 4'b1011;
        rsp_ready = 1'b0;
        repeat (3) begin
            #1;
            chk("bp_ready", 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
            chk("bp_data", rsp_data, 64'd12);
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 64'(req_ready), 64'b1000);
        @(posedge clk);
        #1;
        chk("bp_rel_id", 64'(rsp_id), 64'd3);
        chk("bp_rel_data", rsp_data, 64'd34);
        chk("bp_rel_valid", 64'(rsp_valid), 64'd1);
        chk("bp_rel_cnt", 64'(op_count), 64'd7);

        // Drain with no request: valid drops, contents hold.
        @(negedge clk);
        req_valid = '0;
        @(posedge clk);
        #1;
        chk("drain_valid", 64'(rsp_valid), 64'd0);
        chk("drain_data", rsp_data, 64'd34);
        chk("drain_id", 64'(rsp_id), 64'd3);

        // Subtract overflow on requester 1.
        @(negedge clk);
        req_valid = 4'b0010;
        req_a[1]  = SMAX;
        req_b[1]  = ONES;
        req_op    = 4'b0010;
        @(posedge clk);
        #1;
        chk("sub_ovf_flag", 64'(rsp_ovf), 64'd1);
        chk("sub_ovf_data", rsp_data, EXP_SUB_OVF);
        chk("sub_ovf_id", 64'(rsp_id), 64'd1);

        // Add overflow on requester 0.
        @(negedge clk);
        req_valid = 4'b0001;
        req_a[0]  = SMIN;
        req_b[0]  = ONES;
        req_op    = 4'b0000;
        @(posedge clk);
        #1;
        chk("add_ovf_flag", 64'(rsp_ovf), 64'd1);
        chk("add_ovf_data", rsp_data, EXP_ADD_OVF);
        chk("add_ovf_id", 64'(rsp_id), 64'd0);

        // Plain subtract with negative result, no overflow.
        @(negedge clk);
        req_valid = 4'b0100;
        req_a[2]  = 64'd5;
        req_b[2]  = 64'd7;
        req_op    = 4'b0100;
        @(posedge clk);
        #1;
        chk("sub_neg_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_neg_ovf", 64'(rsp_ovf), 64'd0);
        chk("sub_neg_cnt", 64'(op_count), 64'd10);

        // Asynchronous reset while FULL.
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(rsp_valid), 64'd0);
        chk("arst_cnt", 64'(op_count), 64'd0);
        chk("arst_data", rsp_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        set_rr_operands();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        chk("arst_grant", 64'(req_ready), 64'b0001);
        @(posedge clk);
        #1;
        chk("arst_id", 64'(rsp_id), 64'd0);
        chk("arst_res", rsp_data, 64'd1);
        chk("arst_cnt1", 64'(op_count), 64'd1);

        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Shares one `add` add/subtract unit between `N_REQ` requesters in the non-linear-ops datapath. Arbitration is round-robin, and each requester uses a valid/ready handshake. The block registers one result per cycle into a single-entry output buffer, tags it with the winning requester's index, and flags signed overflow. It sits between the activation/normalisation engines (the requesters) and the shared adder, so several engines can use one adder instead of each instantiating their own.

## Interface
- `WIDTH`, default 64: operand and result width; operands are two's complement.
- `N_REQ`, default 4: number of requesters, minimum 2.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester tag.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  `N_REQ`  per-requester operation valid.
- `req_ready`  out  `N_REQ`  per-requester grant/accept; at most one bit is high.
- `req_op`  in  `N_REQ`  per-requester op select: 0 = add, 1 = subtract (a−b).
- `req_a`  in  `N_REQ`×`WIDTH`  packed operand A array.
- `req_b`  in  `N_REQ`×`WIDTH`  packed operand B array.
- `rsp_valid`  out  1  result buffer holds a valid result.
- `rsp_ready`  in  1  downstream consumes the result.
- `rsp_id`  out  `ID_W`  index of the requester that produced the result.
- `rsp_data`  out  `WIDTH`  result.
- `rsp_ovf`  out  1  signed overflow occurred on this result.
- `op_count`  out  32  count of accepted operations; wraps modulo 2^32.

## Operation
**Reset.**
- Outputs: `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_ovf`=0, `op_count`=0.
- Internal: priority pointer `rr_ptr`=0.

**Buffer state.** The buffer has two states, EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
- `slot_free` = !`rsp_valid` || `rsp_ready`.

**Arbitration** (combinational).
- The winner is the first set `req_valid` bit, searching from `rr_ptr` upward and wrapping from `N_REQ`−1 to 0.
- `req_ready[win]` = `slot_free`; all other `req_ready` bits are 0.
- `req_ready` depends on `req_valid`, `rsp_valid` and `rsp_ready` only. It does not depend on operands or `req_op`.

**Accept** (on a clock edge with `req_valid[i]` && `req_ready[i]`):
- `rsp_data` ← `add` result on `req_a[i]`, `req_b[i]`, `req_op[i]`.
- `rsp_id` ← i; `rsp_ovf` ← overflow flag; `rsp_valid` ← 1.
- `rr_ptr` ← (i+1) mod `N_REQ`; `op_count` increments.

**Drain.**
- On `rsp_valid` && `rsp_ready` with no accept: `rsp_valid` ← 0.
- `rsp_data`, `rsp_id` and `rsp_ovf` hold their last values.

**Simultaneous drain and accept.** The buffer is overwritten with the new result and `rsp_valid` stays 1, giving full throughput of one operation per cycle.

**Stall.** While FULL and `rsp_ready`=0, all `req_ready` are 0 and the buffer contents are stable.

**No request.** `rr_ptr` is unchanged.

**Overflow** (computed on full-width operands):
- Add: a and b have the same sign and the result sign differs.
- Sub: a and b have different signs and the result sign differs from a.

**Reset mid-operation.** Any buffered result is discarded immediately (async); no partial handshake survives.

## Timing
- Latency: 1 cycle from accept edge to `rsp_valid`/`rsp_data` visible.
- Throughput: 1 operation per cycle when `rsp_ready` is held high.
- Fairness: a continuously valid requester is granted within `N_REQ` accepts.
- Requesters must hold `req_valid` and operands stable until accepted. The arbiter never retracts `req_ready` within a cycle unless its inputs change.

## Configuration
- `ADD_ARB_SAT_EN` defined:
  - On overflow, `rsp_data` clamps to the signed maximum (0x7FF…F) when the true result is positive, and to the signed minimum (0x800…0) when negative.
  - `rsp_ovf` is still asserted.
- Undefined: `rsp_data` is the wrapped two's-complement result; `rsp_ovf` is still asserted.

## Structure
- Shared package `nn_ops_pkg`:
  - `addsub_e` enum (ADD=0, SUB=1).
  - Overflow-detect function `ovf_addsub(a, b, r, op)`.
  - Saturation constants derived from `WIDTH`.
- One sub-module: a single instance of the existing `add` as the shared datapath, fed by a one-hot mux of the winner's operands.
- Round-robin pick is in-module logic, not a separate module.

## Test plan
Scenarios use `WIDTH`=64, `N_REQ`=4.
- **Reset.** `rst` pulse during FULL → `rsp_valid`=0, `op_count`=0 asynchronously. First grant after release goes to requester 0 when all are valid.
- **Single add.** Req 2 sends a=5, b=7, op=0 → `req_ready[2]`=1 that cycle. Next cycle: `rsp_valid`=1, `rsp_data`=12, `rsp_id`=2, `rsp_ovf`=0.
- **Round-robin.** All 4 requesters valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0, one result per cycle. `op_count` reaches 5.
- **Backpressure.** `rsp_ready`=0 for 3 cycles while FULL → all `req_ready`=0 and `rsp_data` stable. On release, drain and a new accept occur in the same cycle.
- **Overflow, subtract.** a=0x7FFF_FFFF_FFFF_FFFF, b=−1, op=1 → `rsp_ovf`=1. `rsp_data`=0x8000_0000_0000_0000 without the macro, 0x7FFF_FFFF_FFFF_FFFF with `ADD_ARB_SAT_EN`.
- **Overflow, add.** a=−2^63, b=−1, op=0 → `rsp_ovf`=1. `rsp_data`=0x7FFF…F without the macro, 0x8000…0 with `ADD_ARB_SAT_EN`.
